// File: rtl/simon_i2c_master.sv
// ---------------------------------------------------------------------------
// simon_i2c_master
//   Byte-level I2C initiator. Executes one START / WRITE / READ / STOP command
//   at a time on an open-drain SDA/SCL pair and returns one response per
//   command. Honours responder clock stretching while SCL is being released.
//
// Ports
//   clk, rst_n            system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_op                00 START, 01 WRITE, 10 READ, 11 STOP
//   cmd_data              byte to send on WRITE, MSB first
//   cmd_nack              READ: level driven on the 9th bit (1 = NACK)
//   rsp_valid             one-cycle completion pulse
//   rsp_data              byte received by READ, 0x00 otherwise
//   rsp_nack              WRITE: sampled acknowledge bit (1 = NACK)
//   rsp_err               command not legal in the current bus state
//   bus_owned             high between a completed START and a completed STOP
//   sda_i/sda_o/sda_t     SDA pad triplet (t = 1 releases the line)
//   scl_i/scl_o/scl_t     SCL pad triplet (t = 1 releases the line)
// ---------------------------------------------------------------------------
module simon_i2c_master #(
   parameter int CLK_DIV = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   input  logic       cmd_nack,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_nack,
   output logic       rsp_err,
   output logic       bus_owned,
   input  logic       sda_i,
   output logic       sda_o,
   output logic       sda_t,
   input  logic       scl_i,
   output logic       scl_o,
   output logic       scl_t
);

   localparam logic [9:0] CNT_LAST = 10'(CLK_DIV - 1);

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BIT   = 3'd2,
      ST_STOP  = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   state_t      state_r, state_s;
   logic [1:0]  q_r, q_s;              // quarter within the current phase
   logic [9:0]  cnt_r, cnt_s;          // clocks within the current quarter
   logic [3:0]  bit_r, bit_s;          // bit index 0..8 within a byte
   logic [1:0]  op_r, op_s;
   logic [8:0]  tx_r, tx_s;            // 9-bit stream, MSB is the current bit
   logic [8:0]  rx_r, rx_s;            // 9 SDA samples, last one is the ACK slot
   logic        sda_t_r, sda_t_s;
   logic        scl_t_r, scl_t_s;
   logic        cmd_ready_r, cmd_ready_s;
   logic        rsp_valid_r, rsp_valid_s;
   logic [7:0]  rsp_data_r, rsp_data_s;
   logic        rsp_nack_r, rsp_nack_s;
   logic        rsp_err_r, rsp_err_s;
   logic        bus_owned_r, bus_owned_s;
   logic        stretch_s;
   logic        qend_s;

   // Next-state, line-control and response computation.
   always_comb begin
      state_s     = state_r;
      q_s         = q_r;
      cnt_s       = cnt_r;
      bit_s       = bit_r;
      op_s        = op_r;
      tx_s        = tx_r;
      rx_s        = rx_r;
      sda_t_s     = sda_t_r;
      scl_t_s     = scl_t_r;
      rsp_valid_s = 1'b0;
      rsp_data_s  = rsp_data_r;
      rsp_nack_s  = rsp_nack_r;
      rsp_err_s   = rsp_err_r;
      bus_owned_s = bus_owned_r;

      // While SCL is released in Q1 the quarter does not begin counting until
      // the line is actually seen high; a responder may hold it low forever.
      stretch_s = (q_r == 2'd1) && (cnt_r == 10'd0) && !scl_i;
      qend_s    = (cnt_r == CNT_LAST) && !stretch_s;

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               op_s  = cmd_op;
               q_s   = 2'd0;
               cnt_s = 10'd0;
               bit_s = 4'd0;
               if (cmd_op == OP_READ) begin
                  tx_s = {8'hFF, cmd_nack};
               end else begin
                  tx_s = {cmd_data, 1'b1};
               end
               if (cmd_op == OP_START) begin
                  state_s = ST_START;
                  sda_t_s = 1'b1;
               end else if (!bus_owned_r) begin
                  state_s     = ST_RESP;
                  rsp_valid_s = 1'b1;
                  rsp_data_s  = 8'h00;
                  rsp_nack_s  = 1'b0;
                  rsp_err_s   = 1'b1;
               end else if (cmd_op == OP_STOP) begin
                  state_s = ST_STOP;
                  sda_t_s = 1'b0;
               end else begin
                  state_s = ST_BIT;
                  sda_t_s = tx_s[8];
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_START, ST_BIT, ST_STOP: begin
            // SDA is sampled on the final clock of Q2, SCL high the whole quarter.
            if ((state_r == ST_BIT) && (q_r == 2'd2) && qend_s) begin
               rx_s = {rx_r[7:0], sda_i};
            end else begin
               rx_s = rx_r;
            end

            if (stretch_s) begin
               cnt_s = cnt_r;
            end else if (!qend_s) begin
               cnt_s = cnt_r + 10'd1;
            end else if (q_r != 2'd3) begin
               // Entering Q1..Q3: apply that quarter's line action once.
               cnt_s = 10'd0;
               q_s   = q_r + 2'd1;
               case (q_s)
                  2'd1: begin
                     scl_t_s = 1'b1;
                  end
                  2'd2: begin
                     if (state_r == ST_START) begin
                        sda_t_s = 1'b0;
                     end else if (state_r == ST_STOP) begin
                        sda_t_s = 1'b1;
                     end else begin
                        sda_t_s = sda_t_r;
                     end
                  end
                  2'd3: begin
                     if (state_r == ST_STOP) begin
                        scl_t_s = scl_t_r;
                     end else begin
                        scl_t_s = 1'b0;
                     end
                  end
                  default: begin
                     scl_t_s = scl_t_r;
                  end
               endcase
            end else begin
               // End of Q3: phase complete.
               cnt_s = 10'd0;
               q_s   = 2'd0;
               case (state_r)
                  ST_START: begin
                     bus_owned_s = 1'b1;
                     state_s     = ST_RESP;
                     rsp_valid_s = 1'b1;
                     rsp_data_s  = 8'h00;
                     rsp_nack_s  = 1'b0;
                     rsp_err_s   = 1'b0;
                  end
                  ST_STOP: begin
                     bus_owned_s = 1'b0;
                     state_s     = ST_RESP;
                     rsp_valid_s = 1'b1;
                     rsp_data_s  = 8'h00;
                     rsp_nack_s  = 1'b0;
                     rsp_err_s   = 1'b0;
                  end
                  ST_BIT: begin
                     if (bit_r == 4'd8) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = (op_r == OP_READ)  ? rx_r[8:1] : 8'h00;
                        rsp_nack_s  = (op_r == OP_WRITE) ? rx_r[0]   : 1'b0;
                        rsp_err_s   = 1'b0;
                     end else begin
                        // Rotate so every stored bit stays live; new MSB is the next bit.
                        bit_s   = bit_r + 4'd1;
                        tx_s    = {tx_r[7:0], tx_r[8]};
                        sda_t_s = tx_s[8];
                     end
                  end
                  default: begin
                     state_s = ST_IDLE;
                  end
               endcase
            end
         end

         ST_RESP: begin
            state_s = ST_IDLE;
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase

      cmd_ready_s = (state_s == ST_IDLE);
   end

   // State and registered-output update; reset releases both lines at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         q_r         <= 2'd0;
         cnt_r       <= 10'd0;
         bit_r       <= 4'd0;
         op_r        <= OP_START;
         tx_r        <= 9'h1FF;
         rx_r        <= 9'h000;
         sda_t_r     <= 1'b1;
         scl_t_r     <= 1'b1;
         cmd_ready_r <= 1'b1;
         rsp_valid_r <= 1'b0;
         rsp_data_r  <= 8'h00;
         rsp_nack_r  <= 1'b0;
         rsp_err_r   <= 1'b0;
         bus_owned_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         q_r         <= q_s;
         cnt_r       <= cnt_s;
         bit_r       <= bit_s;
         op_r        <= op_s;
         tx_r        <= tx_s;
         rx_r        <= rx_s;
         sda_t_r     <= sda_t_s;
         scl_t_r     <= scl_t_s;
         cmd_ready_r <= cmd_ready_s;
         rsp_valid_r <= rsp_valid_s;
         rsp_data_r  <= rsp_data_s;
         rsp_nack_r  <= rsp_nack_s;
         rsp_err_r   <= rsp_err_s;
         bus_owned_r <= bus_owned_s;
      end
   end

   assign cmd_ready = cmd_ready_r;
   assign rsp_valid = rsp_valid_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_nack  = rsp_nack_r;
   assign rsp_err   = rsp_err_r;
   assign bus_owned = bus_owned_r;
   assign sda_t     = sda_t_r;
   assign scl_t     = scl_t_r;
   assign sda_o     = 1'b0;
   assign scl_o     = 1'b0;

endmodule

// File: tb/tb_simon_i2c_master.sv
// ---------------------------------------------------------------------------
// tb_simon_i2c_master
//   Self-checking bench for simon_i2c_master. A small responder model drives
//   SDA on the open-drain bus and can stretch SCL; expected responses are
//   queued when a command is issued and compared when rsp_valid appears.
// ---------------------------------------------------------------------------
module tb_simon_i2c_master;

   localparam int D        = 4;
   localparam int LAT_SS   = 4 * D + 1;
   localparam int LAT_BYTE = 36 * D + 1;
   localparam int STRETCH  = 100;

   localparam logic [1:0] OP_START = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_READ  = 2'b10;
   localparam logic [1:0] OP_STOP  = 2'b11;

   typedef struct {
      logic [7:0] data;
      logic       nack;
      logic       err;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic       cmd_nack;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_nack;
   logic       rsp_err;
   logic       bus_owned;
   logic       sda_o, sda_t, scl_o, scl_t;
   logic       sda_bus, scl_bus;
   logic       slave_sda;
   logic       stretch = 1'b0;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Open-drain bus: a line is low if anybody pulls it low.
   assign sda_bus = sda_t & slave_sda;
   assign scl_bus = scl_t & ~stretch;

   simon_i2c_master #(.CLK_DIV(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .cmd_nack  (cmd_nack),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_nack  (rsp_nack),
      .rsp_err   (rsp_err),
      .bus_owned (bus_owned),
      .sda_i     (sda_bus),
      .sda_o     (sda_o),
      .sda_t     (sda_t),
      .scl_i     (scl_bus),
      .scl_o     (scl_o),
      .scl_t     (scl_t)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // SCL falling edges pace the responder model.
   int scl_falls = 0;
   always @(negedge scl_bus) scl_falls <= scl_falls + 1;

   // Counts clocks on which the master drives either line low.
   int drive_cnt = 0;
   always @(negedge clk) if (!sda_t || !scl_t) drive_cnt <= drive_cnt + 1;

   // Bus SDA and master SDA enable captured on every SCL rising edge.
   logic [8:0] sda_bits = 9'h000;
   logic [8:0] mst_bits = 9'h000;
   always @(posedge scl_bus) begin
      sda_bits <= {sda_bits[7:0], sda_bus};
      mst_bits <= {mst_bits[7:0], sda_t};
   end

   // Responder model: presents pattern bit k after the k-th SCL fall.
   logic       slv_en   = 1'b0;
   logic [8:0] slv_pat  = 9'h1FF;
   int         slv_base = 0;
   int         slv_k;
   logic [8:0] slv_sh;
   always_comb begin
      slv_k  = scl_falls - slv_base;
      slv_sh = slv_pat << slv_k;
      if (slv_en && (slv_k >= 0) && (slv_k <= 8)) slave_sda = slv_sh[8];
      else                                       slave_sda = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic slave_load(input logic [8:0] pat);
      slv_pat  = pat;
      slv_base = scl_falls;
      slv_en   = 1'b1;
   endtask

   // Drive one command, queue its expected response, then compare on rsp_valid.
   task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic nack,
                        input logic [7:0] e_data, input logic e_nack, input logic e_err,
                        input int e_lat);
      int   guard;
      int   issue_cyc;
      exp_t e;
      @(negedge clk);
      guard = 0;
      while (!cmd_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      cmd_nack  = nack;
      e.data = e_data;
      e.nack = e_nack;
      e.err  = e_err;
      e.lat  = e_lat;
      sb_q.push_back(e);
      issue_cyc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = ~op;
      cmd_data  = ~data;
      cmd_nack  = ~nack;
      check("cmd_ready_fall", 32'(cmd_ready), 32'd0);
      guard = 0;
      while (!rsp_valid && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      check("rsp_seen", 32'(rsp_valid), 32'd1);
      e = sb_q.pop_front();
      check("rsp_data", 32'(rsp_data), 32'(e.data));
      check("rsp_nack", 32'(rsp_nack), 32'(e.nack));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
      check("latency", 32'(cyc - issue_cyc), 32'(e.lat));
      @(negedge clk);
      check("rsp_pulse", 32'(rsp_valid), 32'd0);
      check("cmd_ready_rise", 32'(cmd_ready), 32'd1);
   endtask

   // Responder holds SCL low from bit 3's Q0 until 100 clocks after release.
   task automatic stretch_bit3(input int base);
      int guard;
      guard = 0;
      while ((scl_falls - base) < 2 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      stretch = 1'b1;
      guard = 0;
      while (!scl_t && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      repeat (STRETCH) @(posedge clk);
      @(negedge clk);
      stretch = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      int drv0;
      int guard;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_START;
      cmd_data  = 8'h00;
      cmd_nack  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sda_t", 32'(sda_t), 32'd1);
      check("rst_scl_t", 32'(scl_t), 32'd1);
      check("rst_pads_o", 32'({sda_o, scl_o}), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp", 32'({rsp_valid, rsp_data, rsp_nack, rsp_err}), 32'd0);
      check("rst_bus_owned", 32'(bus_owned), 32'd0);
      rst_n = 1'b1;

      // Byte command while the bus is not owned: immediate error, lines untouched.
      drv0 = drive_cnt;
      issue(OP_READ, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1);
      check("err_no_drive", 32'(drive_cnt - drv0), 32'd0);

      // START, addressed WRITE acknowledged by the responder.
      issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      check("owned_after_start", 32'(bus_owned), 32'd1);
      slave_load(9'b1111_1111_0);
      issue(OP_WRITE, 8'h54, 1'b0, 8'h00, 1'b0, 1'b0, LAT_BYTE);
      check("write_sda_bits", 32'(sda_bits[8:1]), 32'h54);
      check("write_ack_bit", 32'(sda_bits[0]), 32'd0);

      // Same byte with nobody answering.
      slv_en = 1'b0;
      issue(OP_WRITE, 8'h54, 1'b0, 8'h00, 1'b1, 1'b0, LAT_BYTE);
      check("write_nack_bit", 32'(sda_bits[0]), 32'd1);

      // Repeated START, READ with ACK, then READ with NACK.
      issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      slave_load({8'h3C, 1'b1});
      issue(OP_READ, 8'h00, 1'b0, 8'h3C, 1'b0, 1'b0, LAT_BYTE);
      check("read_ack_mst", 32'(mst_bits), 32'h1FE);
      slave_load({8'hA5, 1'b1});
      issue(OP_READ, 8'h00, 1'b1, 8'hA5, 1'b0, 1'b0, LAT_BYTE);
      check("read_nack_mst", 32'(mst_bits), 32'h1FF);
      check("read_nack_bus", 32'(sda_bits), 32'({8'hA5, 1'b1}));

      // WRITE with 100-clock stretch on bit 3.
      issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      slave_load(9'b1111_1111_0);
      base = scl_falls;
      fork
         stretch_bit3(base);
         issue(OP_WRITE, 8'hC3, 1'b0, 8'h00, 1'b0, 1'b0, LAT_BYTE + STRETCH);
      join
      check("stretch_sda_bits", 32'(sda_bits), 32'({8'hC3, 1'b0}));
      slv_en = 1'b0;

      // STOP releases the bus.
      issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      check("owned_after_stop", 32'(bus_owned), 32'd0);
      check("bus_idle", 32'({sda_bus, scl_bus}), 32'd3);
      issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1);
      issue(OP_WRITE, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1);

      // Reset during bit 5 of a WRITE.
      issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      slave_load(9'b1111_1111_0);
      base = scl_falls;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = OP_WRITE;
      cmd_data  = 8'h54;
      @(negedge clk);
      cmd_valid = 1'b0;
      guard = 0;
      while ((scl_falls - base) < 4 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      repeat (D) @(negedge clk);
      check("pre_rst_scl_t", 32'(scl_t), 32'd0);
      check("pre_rst_sda_t", 32'(sda_t), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_lines", 32'({sda_t, scl_t}), 32'd3);
      check("async_rst_ready", 32'(cmd_ready), 32'd1);
      check("async_rst_owned", 32'(bus_owned), 32'd0);
      check("async_rst_rsp", 32'({rsp_valid, rsp_data, rsp_nack, rsp_err}), 32'd0);
      slv_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      issue(OP_START, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      issue(OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, LAT_SS);
      check("recover_bus_idle", 32'({sda_bus, scl_bus, bus_owned}), 32'd6);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/simon_i2c_master.md
# simon_i2c_master

Byte-level I2C controller: the initiator end of the two-wire link that the SIMON I2C responder serves. Sits between a command-issuing block and the open-drain SDA/SCL pad pair. Executes START, WRITE-byte, READ-byte and STOP commands one at a time, honours responder clock stretching, and returns one response per command. Drives pads through the same `_i/_o/_t` triplet convention as the responder, so the two can be wired back-to-back in simulation.

## Interface
- `CLK_DIV`, 25: system clocks per SCL quarter-period; legal range 2..1023; SCL period = 4·CLK_DIV clocks.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high when idle; a command is accepted on a cycle with `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  00 START, 01 WRITE, 10 READ, 11 STOP.
- `cmd_data`  in  8  byte for WRITE, MSB first.
- `cmd_nack`  in  1  READ only: 1 = master sends NACK after the byte, 0 = ACK.
- `rsp_valid`  out  1  one-cycle pulse on command completion; no backpressure.
- `rsp_data`  out  8  byte received by READ; 0x00 for other ops.
- `rsp_nack`  out  1  WRITE: sampled ACK bit (1 = responder NACKed); 0 otherwise.
- `rsp_err`  out  1  command illegal in current bus state (see Operation).
- `bus_owned`  out  1  high between a completed START and a completed STOP.
- `sda_i`, `scl_i`  in  1  pad levels.
- `sda_o`, `scl_o`  out  1  tied 0 (open-drain).
- `sda_t`, `scl_t`  out  1  1 = release (high-Z), 0 = drive low.

## Operation
- States: IDLE, START, BIT, STOP, RESP. Every non-IDLE phase is four quarters Q0..Q3 of CLK_DIV clocks each.
- START (legal always; repeated START when owned): Q0 release SDA; Q1 release SCL; Q2 drive SDA low; Q3 drive SCL low. Sets `bus_owned`.
- BIT (9 per WRITE/READ): Q0 set SDA (drive low for 0, release for 1) with SCL low; Q1 release SCL; Q2 SCL high; Q3 drive SCL low.
- WRITE: bits 8..1 = `cmd_data[7:0]`; bit 9 SDA released, ACK sampled.
- READ: bits 8..1 SDA released, sampled into shift register MSB first; bit 9 drives `cmd_nack` level.
- STOP: Q0 drive SDA low; Q1 release SCL; Q2 release SDA; Q3 idle. Clears `bus_owned`.
- WRITE/READ/STOP with `bus_owned` = 0: no bus activity; RESP next cycle with `rsp_err` = 1.
- Clock stretching: Q1 quarter counter does not start until `scl_i` = 1 is seen; stretch unbounded.
- RESP: one cycle, pulse `rsp_valid` with outputs, return to IDLE.
- `cmd_op`/`cmd_data`/`cmd_nack` captured at accept; later input changes have no effect.

## Timing
- Reset values: `sda_t`=`scl_t`=1, `sda_o`=`scl_o`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0x00, `rsp_nack`=`rsp_err`=0, `bus_owned`=0.
- Reset asserted mid-transfer releases both lines immediately (async); no STOP generated; caller issues START then STOP to recover.
- `cmd_ready` falls the cycle after accept, rises in the cycle after `rsp_valid`.
- Latency accept→`rsp_valid` without stretching: START/STOP 4·CLK_DIV+1; WRITE/READ 36·CLK_DIV+1; error 1.
- SDA sampled on the last clock of Q2 (SCL high ≥ CLK_DIV clocks).
- SDA changes only in Q0 while SCL low, except START/STOP edges.

## Test plan
- START, WRITE 0x54 (addr 0x2A+W) to responder model that ACKs, STOP → SDA bit pattern 0101_0100, `rsp_nack`=0, `bus_owned` 1 then 0, bus released.
- WRITE 0x54 with no responder → `rsp_nack`=1, `rsp_err`=0.
- START, READ `cmd_nack`=1 from model sending 0xA5 → `rsp_data`=0xA5, SDA released on 9th bit, then STOP.
- Responder holds SCL low 100 clocks on bit 3 → latency grows by exactly 100 clocks, data intact.
- READ with bus not owned → `rsp_err`=1 one cycle after accept, SCL/SDA never driven.
- `rst_n` low during bit 5 of WRITE (CLK_DIV=4) → `sda_t`=`scl_t`=1 same cycle, all outputs at reset values, `cmd_ready`=1 after release.
